rv32i_dxm_pipe: RTL and testbench

//  Parametrised RV32I integer decode->execute->memory-issue pipeline: register file, decoder, ALU,
//  and D/E/M pipeline registers. Adds a valid/ready issue handshake, a register scoreboard and
//  RAW/WAW hazard stalls. Feeds the data-memory/writeback stage; writeback returns via addr_3/wd_3/we.

---
 rtl/rv32i_dxm_pipe.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_rv32i_dxm_pipe.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_dxm_pipe.sv
// rv32i_dxm_pipe: RV32I decode -> execute -> memory-issue pipeline with register file, ALU and scoreboard.
// Define RV32I_FWD_EN to forward E/M ALU results into decode; otherwise pending operands stall until writeback.
module rv32i_dxm_pipe #(
  parameter int DPW = 32,
  parameter int ADW = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    instrD,
  input  logic           instr_valid,
  output logic           instr_ready,
  input  logic [ADW-1:0] addr_3,
  input  logic [DPW-1:0] wd_3,
  input  logic           we,
  output logic           validM,
  output logic           regwriteM,
  output logic           resultsrcM,
  output logic           memwriteM,
  output logic [DPW-1:0] aluresultM,
  output logic [DPW-1:0] Rd2M,
  output logic [ADW-1:0] RdM,
  output logic           illegalD
);
  localparam int NREG = 2 ** ADW;
  localparam int SHW  = $clog2(DPW);
  localparam logic [6:0] OP_R  = 7'd51;
  localparam logic [6:0] OP_I  = 7'd19;
  localparam logic [6:0] OP_LD = 7'd3;
  localparam logic [6:0] OP_ST = 7'd35;
  localparam logic [1:0] SEL_RF    = 2'd0;
  localparam logic [1:0] SEL_E     = 2'd1;
  localparam logic [1:0] SEL_M     = 2'd2;
  localparam logic [1:0] SEL_STALL = 2'd3;

  function automatic logic [DPW-1:0] sext12(input logic [11:0] v);
    logic [DPW+11:0] w;
    w = {{DPW{v[11]}}, v};
    return w[DPW-1:0];
  endfunction

  // Youngest in-flight writer of a register decides: forward an ALU result, or stall on a load/pending value.
  function automatic logic [1:0] src_sel(
    input logic [ADW-1:0] a,
    input logic           pend,
    input logic           e_w,
    input logic           e_ld,
    input logic [ADW-1:0] e_rd,
    input logic           m_w,
    input logic           m_ld,
    input logic [ADW-1:0] m_rd
  );
    logic [1:0] sel;
    if (e_w && (e_rd == a)) begin
      sel = e_ld ? SEL_STALL : SEL_E;
    end else if (m_w && (m_rd == a)) begin
      sel = m_ld ? SEL_STALL : SEL_M;
    end else begin
      sel = pend ? SEL_STALL : SEL_RF;
    end
    return sel;
  endfunction

  logic [DPW-1:0]  rf_q [NREG];
  logic [DPW-1:0]  rf_d [NREG];
  logic [NREG-1:0] pending_q, pending_d;

  logic           valid_e_q, valid_e_d, regwrite_e_q, regwrite_e_d;
  logic           resultsrc_e_q, resultsrc_e_d, memwrite_e_q, memwrite_e_d;
  logic           alt_e_q, alt_e_d;
  logic [2:0]     f3_e_q, f3_e_d;
  logic [DPW-1:0] srca_e_q, srca_e_d, srcb_e_q, srcb_e_d, rd2_e_q, rd2_e_d;
  logic [ADW-1:0] rd_e_q, rd_e_d;

  logic           valid_m_q, valid_m_d, regwrite_m_q, regwrite_m_d;
  logic           resultsrc_m_q, resultsrc_m_d, memwrite_m_q, memwrite_m_d;
  logic [DPW-1:0] aluresult_m_q, aluresult_m_d, rd2_m_q, rd2_m_d;
  logic [ADW-1:0] rd_m_q, rd_m_d;
  logic           illegal_q, illegal_d;

  logic [6:0]      opcode_s;
  logic [2:0]      funct3_s;
  logic [ADW-1:0]  rd_s, rs1_s, rs2_s;
  logic            is_r_s, is_i_s, is_ld_s, is_st_s, legal_s, use_rs2_s, wr_rd_s;
  logic [DPW-1:0]  imm_s, rd1_s, rd2_s, op1_s, op2_s, alu_res_s;
  logic [NREG-1:0] clr_mask_s, set_mask_s, pend_eff_s;
  logic [1:0]      sel1_s, sel2_s, seld_s;
  logic            fwd_en_s, e_fw_s, m_fw_s, stall_s, transfer_s;

`ifdef RV32I_FWD_EN
  assign fwd_en_s = 1'b1;
`else
  assign fwd_en_s = 1'b0;
`endif

  // Field extraction and instruction class decode for D
  always_comb begin
    opcode_s  = instrD[6:0];
    funct3_s  = instrD[14:12];
    rd_s      = ADW'(instrD[11:7]);
    rs1_s     = ADW'(instrD[19:15]);
    rs2_s     = ADW'(instrD[24:20]);
    is_r_s    = (opcode_s == OP_R);
    is_i_s    = (opcode_s == OP_I);
    is_ld_s   = (opcode_s == OP_LD);
    is_st_s   = (opcode_s == OP_ST);
    legal_s   = is_r_s | is_i_s | is_ld_s | is_st_s;
    use_rs2_s = is_r_s | is_st_s;
    wr_rd_s   = (is_r_s | is_i_s | is_ld_s) & (rd_s != {ADW{1'b0}});
    if (is_st_s) begin
      imm_s = sext12({instrD[31:25], instrD[11:7]});
    end else begin
      imm_s = sext12(instrD[31:20]);
    end
  end

  // Register file reads; a same-cycle writeback to the read address is bypassed
  always_comb begin
    if (rs1_s == {ADW{1'b0}}) begin
      rd1_s = {DPW{1'b0}};
    end else if (we && (addr_3 == rs1_s)) begin
      rd1_s = wd_3;
    end else begin
      rd1_s = rf_q[rs1_s];
    end
    if (rs2_s == {ADW{1'b0}}) begin
      rd2_s = {DPW{1'b0}};
    end else if (we && (addr_3 == rs2_s)) begin
      rd2_s = wd_3;
    end else begin
      rd2_s = rf_q[rs2_s];
    end
  end

  // Hazard detection and operand selection; a writeback this cycle already releases its register
  always_comb begin
    clr_mask_s = we ? ({{(NREG-1){1'b0}}, 1'b1} << addr_3) : {NREG{1'b0}};
    pend_eff_s = pending_q & ~clr_mask_s;
    e_fw_s     = fwd_en_s & valid_e_q & regwrite_e_q;
    m_fw_s     = fwd_en_s & valid_m_q & regwrite_m_q;
    sel1_s = src_sel(rs1_s, pend_eff_s[rs1_s], e_fw_s, resultsrc_e_q, rd_e_q,
                     m_fw_s, resultsrc_m_q, rd_m_q);
    sel2_s = src_sel(rs2_s, pend_eff_s[rs2_s], e_fw_s, resultsrc_e_q, rd_e_q,
                     m_fw_s, resultsrc_m_q, rd_m_q);
    seld_s = src_sel(rd_s, pend_eff_s[rd_s], e_fw_s, resultsrc_e_q, rd_e_q,
                     m_fw_s, resultsrc_m_q, rd_m_q);
    stall_s = legal_s & ((sel1_s == SEL_STALL) |
                         (use_rs2_s & (sel2_s == SEL_STALL)) |
                         (wr_rd_s & (seld_s == SEL_STALL)));
    case (sel1_s)
      SEL_E:   op1_s = alu_res_s;
      SEL_M:   op1_s = aluresult_m_q;
      default: op1_s = rd1_s;
    endcase
    case (sel2_s)
      SEL_E:   op2_s = alu_res_s;
      SEL_M:   op2_s = aluresult_m_q;
      default: op2_s = rd2_s;
    endcase
  end

  assign instr_ready = ~rst & ~(instr_valid & stall_s);
  assign transfer_s  = instr_valid & instr_ready;

  // E-stage ALU; its result also feeds the E->D forward path
  always_comb begin
    case (f3_e_q)
      3'b000:  alu_res_s = alt_e_q ? (srca_e_q - srcb_e_q) : (srca_e_q + srcb_e_q);
      3'b001:  alu_res_s = srca_e_q << srcb_e_q[SHW-1:0];
      3'b010:  alu_res_s = {{(DPW-1){1'b0}}, ($signed(srca_e_q) < $signed(srcb_e_q))};
      3'b011:  alu_res_s = {{(DPW-1){1'b0}}, (srca_e_q < srcb_e_q)};
      3'b100:  alu_res_s = srca_e_q ^ srcb_e_q;
      3'b101:  alu_res_s = alt_e_q ? DPW'($signed(srca_e_q) >>> srcb_e_q[SHW-1:0])
                                   : (srca_e_q >> srcb_e_q[SHW-1:0]);
      3'b110:  alu_res_s = srca_e_q | srcb_e_q;
      3'b111:  alu_res_s = srca_e_q & srcb_e_q;
      default: alu_res_s = {DPW{1'b0}};
    endcase
  end

  // D->E next state; stalls and unsupported opcodes become all-zero bubbles
  always_comb begin
    valid_e_d = transfer_s & legal_s;
    illegal_d = transfer_s & ~legal_s;
    if (transfer_s && legal_s) begin
      regwrite_e_d  = wr_rd_s;
      resultsrc_e_d = is_ld_s;
      memwrite_e_d  = is_st_s;
      f3_e_d        = (is_r_s | is_i_s) ? funct3_s : 3'b000;
      alt_e_d       = instrD[30] & ((is_r_s & (funct3_s == 3'b000)) |
                                    ((is_r_s | is_i_s) & (funct3_s == 3'b101)));
      srca_e_d      = op1_s;
      srcb_e_d      = is_r_s ? op2_s : imm_s;
      rd2_e_d       = use_rs2_s ? op2_s : {DPW{1'b0}};
      rd_e_d        = is_st_s ? {ADW{1'b0}} : rd_s;
    end else begin
      regwrite_e_d  = 1'b0;
      resultsrc_e_d = 1'b0;
      memwrite_e_d  = 1'b0;
      f3_e_d        = 3'b000;
      alt_e_d       = 1'b0;
      srca_e_d      = {DPW{1'b0}};
      srcb_e_d      = {DPW{1'b0}};
      rd2_e_d       = {DPW{1'b0}};
      rd_e_d        = {ADW{1'b0}};
    end
  end

  // E->M next state and scoreboard update; a set on entry to E wins over a same-edge clear
  always_comb begin
    valid_m_d     = valid_e_q;
    regwrite_m_d  = regwrite_e_q;
    resultsrc_m_d = resultsrc_e_q;
    memwrite_m_d  = memwrite_e_q;
    aluresult_m_d = alu_res_s;
    rd2_m_d       = rd2_e_q;
    rd_m_d        = rd_e_q;
    set_mask_s    = regwrite_e_d ? ({{(NREG-1){1'b0}}, 1'b1} << rd_s) : {NREG{1'b0}};
    pending_d     = ((pending_q & ~clr_mask_s) | set_mask_s) & ~{{(NREG-1){1'b0}}, 1'b1};
  end

  // Register file write port; x0 stays zero
  always_comb begin
    rf_d = rf_q;
    if (we && (addr_3 != {ADW{1'b0}})) begin
      rf_d[addr_3] = wd_3;
    end else begin
      rf_d[0] = {DPW{1'b0}};
    end
  end

  // Register file and scoreboard state
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) rf_q[i] <= {DPW{1'b0}};
      pending_q <= {NREG{1'b0}};
    end else begin
      rf_q      <= rf_d;
      pending_q <= pending_d;
    end
  end

  // E and M pipeline registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_e_q     <= 1'b0;
      regwrite_e_q  <= 1'b0;
      resultsrc_e_q <= 1'b0;
      memwrite_e_q  <= 1'b0;
      f3_e_q        <= 3'b000;
      alt_e_q       <= 1'b0;
      srca_e_q      <= {DPW{1'b0}};
      srcb_e_q      <= {DPW{1'b0}};
      rd2_e_q       <= {DPW{1'b0}};
      rd_e_q        <= {ADW{1'b0}};
      valid_m_q     <= 1'b0;
      regwrite_m_q  <= 1'b0;
      resultsrc_m_q <= 1'b0;
      memwrite_m_q  <= 1'b0;
      aluresult_m_q <= {DPW{1'b0}};
      rd2_m_q       <= {DPW{1'b0}};
      rd_m_q        <= {ADW{1'b0}};
      illegal_q     <= 1'b0;
    end else begin
      valid_e_q     <= valid_e_d;
      regwrite_e_q  <= regwrite_e_d;
      resultsrc_e_q <= resultsrc_e_d;
      memwrite_e_q  <= memwrite_e_d;
      f3_e_q        <= f3_e_d;
      alt_e_q       <= alt_e_d;
      srca_e_q      <= srca_e_d;
      srcb_e_q      <= srcb_e_d;
      rd2_e_q       <= rd2_e_d;
      rd_e_q        <= rd_e_d;
      valid_m_q     <= valid_m_d;
      regwrite_m_q  <= regwrite_m_d;
      resultsrc_m_q <= resultsrc_m_d;
      memwrite_m_q  <= memwrite_m_d;
      aluresult_m_q <= aluresult_m_d;
      rd2_m_q       <= rd2_m_d;
      rd_m_q        <= rd_m_d;
      illegal_q     <= illegal_d;
    end
  end

  assign validM     = valid_m_q;
  assign regwriteM  = regwrite_m_q;
  assign resultsrcM = resultsrc_m_q;
  assign memwriteM  = memwrite_m_q;
  assign aluresultM = aluresult_m_q;
  assign Rd2M       = rd2_m_q;
  assign RdM        = rd_m_q;
  assign illegalD   = illegal_q;

endmodule

// File: tb/tb_rv32i_dxm_pipe.sv
// Bench for rv32i_dxm_pipe: a vector table of ALU/load/store ops plus hand-written hazard and reset sequences,
// checked through an M-stage scoreboard. Expectations follow RV32I_FWD_EN when it is defined.
module tb_rv32i_dxm_pipe;
  logic        clk, rst, instr_valid, instr_ready, we;
  logic [31:0] instrD, wd_3, aluresultM, Rd2M;
  logic [4:0]  addr_3, RdM;
  logic        validM, regwriteM, resultsrcM, memwriteM, illegalD;

  rv32i_dxm_pipe #(.DPW(32), .ADW(5)) dut (
    .clk(clk), .rst(rst), .instrD(instrD), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .addr_3(addr_3), .wd_3(wd_3), .we(we), .validM(validM), .regwriteM(regwriteM),
    .resultsrcM(resultsrcM), .memwriteM(memwriteM), .aluresultM(aluresultM), .Rd2M(Rd2M),
    .RdM(RdM), .illegalD(illegalD)
  );

  typedef struct packed {
    logic [31:0] alu;
    logic [31:0] rd2;
    logic [4:0]  rd;
    logic        rw;
    logic        rs;
    logic        mw;
    logic        chk_rd2;
    logic        chk_rd;
    logic [31:0] due;
  } exp_t;

  typedef struct packed {
    logic [31:0] ins;
    exp_t        e;
  } vec_t;

  exp_t sb_q[$];
  vec_t tbl[17];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] rs2, logic [4:0] rs1,
                                        logic [2:0] f3, logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'd51};
  endfunction

  function automatic logic [31:0] enc_i(logic [11:0] imm, logic [4:0] rs1, logic [2:0] f3,
                                        logic [4:0] rd, logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_s(logic [11:0] imm, logic [4:0] rs2, logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'd2, imm[4:0], 7'd35};
  endfunction

  function automatic exp_t mk(logic [31:0] alu, logic [31:0] rd2, logic [4:0] rd, logic rw,
                              logic rs, logic mw, logic crd2, logic crd);
    exp_t e;
    e.alu = alu; e.rd2 = rd2; e.rd = rd; e.rw = rw; e.rs = rs; e.mw = mw;
    e.chk_rd2 = crd2; e.chk_rd = crd; e.due = 32'd0;
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic sb_check();
    exp_t e;
    if (sb_q.size() > 0 && sb_q[0].due == 32'(cyc)) begin
      e = sb_q.pop_front();
      chk("validM", {31'd0, validM}, 32'd1);
      chk("regwriteM", {31'd0, regwriteM}, {31'd0, e.rw});
      chk("resultsrcM", {31'd0, resultsrcM}, {31'd0, e.rs});
      chk("memwriteM", {31'd0, memwriteM}, {31'd0, e.mw});
      chk("aluresultM", aluresultM, e.alu);
      if (e.chk_rd2) chk("Rd2M", Rd2M, e.rd2);
      if (e.chk_rd) chk("RdM", {27'd0, RdM}, {27'd0, e.rd});
    end else begin
      chk("validM_bubble", {31'd0, validM}, 32'd0);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    #1;
    sb_check();
  endtask

  task automatic send(input logic [31:0] ins, input logic exp_rdy, input exp_t e, input logic push);
    instrD = ins;
    instr_valid = 1'b1;
    #1;
    chk("instr_ready", {31'd0, instr_ready}, {31'd0, exp_rdy});
    if (exp_rdy && push) begin
      e.due = 32'(cyc + 2);
      sb_q.push_back(e);
    end
    cycle();
  endtask

  task automatic stall_cycle(input string nm);
    #1;
    chk(nm, {31'd0, instr_ready}, 32'd0);
    cycle();
  endtask

  task automatic wb(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; addr_3 = a; wd_3 = d;
    cycle();
    we = 1'b0;
  endtask

  task automatic idle(input int n);
    instr_valid = 1'b0;
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, instr_ready}, 32'd0);
    chk({tag, "_validM"}, {31'd0, validM}, 32'd0);
    chk({tag, "_ctl"}, {29'd0, regwriteM, resultsrcM, memwriteM}, 32'd0);
    chk({tag, "_alu"}, aluresultM, 32'd0);
    chk({tag, "_rd2"}, Rd2M, 32'd0);
    chk({tag, "_rdm"}, {27'd0, RdM}, 32'd0);
    chk({tag, "_illegal"}, {31'd0, illegalD}, 32'd0);
  endtask

  initial begin
    tbl[0]  = '{enc_r(7'h20, 5'd22, 5'd21, 3'd5, 5'd5),    mk(32'hF800_0001, 32'd4, 5'd5, 1, 0, 0, 1, 1)};
    tbl[1]  = '{enc_r(7'h00, 5'd11, 5'd10, 3'd0, 5'd6),    mk(32'd4, 32'hFFFF_FFFD, 5'd6, 1, 0, 0, 1, 1)};
    tbl[2]  = '{enc_r(7'h20, 5'd11, 5'd10, 3'd0, 5'd7),    mk(32'd10, 32'hFFFF_FFFD, 5'd7, 1, 0, 0, 1, 1)};
    tbl[3]  = '{enc_r(7'h00, 5'd10, 5'd11, 3'd2, 5'd8),    mk(32'd1, 32'd7, 5'd8, 1, 0, 0, 1, 1)};
    tbl[4]  = '{enc_r(7'h00, 5'd10, 5'd11, 3'd3, 5'd9),    mk(32'd0, 32'd7, 5'd9, 1, 0, 0, 1, 1)};
    tbl[5]  = '{enc_r(7'h00, 5'd22, 5'd21, 3'd5, 5'd13),   mk(32'h0800_0001, 32'd4, 5'd13, 1, 0, 0, 1, 1)};
    tbl[6]  = '{enc_r(7'h00, 5'd22, 5'd10, 3'd1, 5'd14),   mk(32'h70, 32'd4, 5'd14, 1, 0, 0, 1, 1)};
    tbl[7]  = '{enc_r(7'h00, 5'd12, 5'd10, 3'd4, 5'd15),   mk(32'hF7, 32'hF0, 5'd15, 1, 0, 0, 1, 1)};
    tbl[8]  = '{enc_r(7'h00, 5'd11, 5'd12, 3'd7, 5'd16),   mk(32'hF0, 32'hFFFF_FFFD, 5'd16, 1, 0, 0, 1, 1)};
    tbl[9]  = '{enc_r(7'h00, 5'd12, 5'd10, 3'd6, 5'd17),   mk(32'hF7, 32'hF0, 5'd17, 1, 0, 0, 1, 1)};
    tbl[10] = '{enc_i(12'hFF8, 5'd10, 3'd0, 5'd18, 7'd19), mk(32'hFFFF_FFFF, 32'd0, 5'd18, 1, 0, 0, 0, 1)};
    tbl[11] = '{enc_i(12'h404, 5'd21, 3'd5, 5'd19, 7'd19), mk(32'hF800_0001, 32'd0, 5'd19, 1, 0, 0, 0, 1)};
    tbl[12] = '{enc_i(12'hFFE, 5'd11, 3'd2, 5'd20, 7'd19), mk(32'd1, 32'd0, 5'd20, 1, 0, 0, 0, 1)};
    tbl[13] = '{enc_i(12'h00F, 5'd12, 3'd4, 5'd23, 7'd19), mk(32'hFF, 32'd0, 5'd23, 1, 0, 0, 0, 1)};
    tbl[14] = '{enc_i(12'hFFF, 5'd10, 3'd3, 5'd24, 7'd19), mk(32'd1, 32'd0, 5'd24, 1, 0, 0, 0, 1)};
    tbl[15] = '{enc_i(12'h010, 5'd10, 3'd2, 5'd25, 7'd3),  mk(32'h17, 32'd0, 5'd25, 1, 1, 0, 0, 1)};
    tbl[16] = '{enc_s(12'hFFC, 5'd10, 5'd12),              mk(32'hEC, 32'd7, 5'd0, 0, 0, 1, 1, 0)};

    rst = 1'b1; instr_valid = 1'b0; instrD = 32'd0; we = 1'b0; addr_3 = 5'd0; wd_3 = 32'd0;
    #2;
    chk_zero("por");
    cycle();
    cycle();
    rst = 1'b0;
    #1;
    chk("ready_after_reset", {31'd0, instr_ready}, 32'd1);

    // operand preload
    wb(5'd21, 32'h8000_0010);
    wb(5'd22, 32'd4);
    wb(5'd10, 32'd7);
    wb(5'd11, 32'hFFFF_FFFD);
    wb(5'd12, 32'hF0);

    for (int i = 0; i < 17; i++) send(tbl[i].ins, 1'b1, tbl[i].e, 1'b1);
    idle(2);
    for (int i = 0; i < 17; i++) if (tbl[i].e.rw) wb(tbl[i].e.rd, tbl[i].e.alu);

    // ADDI x1,x0,5 ; ADD x2,x1,x1
    send(enc_i(12'd5, 5'd0, 3'd0, 5'd1, 7'd19), 1'b1, mk(32'd5, 32'd0, 5'd1, 1, 0, 0, 0, 1), 1'b1);
`ifdef RV32I_FWD_EN
    send(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 1'b1, mk(32'd10, 32'd5, 5'd2, 1, 0, 0, 1, 1), 1'b1);
`else
    instrD = enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2);
    instr_valid = 1'b1;
    stall_cycle("raw_stall_e");
    stall_cycle("raw_stall_m");
    we = 1'b1; addr_3 = 5'd1; wd_3 = 32'd5;
    send(enc_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd2), 1'b1, mk(32'd10, 32'd5, 5'd2, 1, 0, 0, 1, 1), 1'b1);
    we = 1'b0;
`endif
    idle(2);
    wb(5'd1, 32'd5);
    wb(5'd2, 32'd10);

    // LW x3,8(x0) ; ADD x4,x3,x3 waits for the load writeback in every build
    send(enc_i(12'd8, 5'd0, 3'd2, 5'd3, 7'd3), 1'b1, mk(32'd8, 32'd0, 5'd3, 1, 1, 0, 0, 1), 1'b1);
    instrD = enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4);
    instr_valid = 1'b1;
    stall_cycle("load_stall_e");
    stall_cycle("load_stall_m");
    stall_cycle("load_stall_pend");
    we = 1'b1; addr_3 = 5'd3; wd_3 = 32'h55;
    send(enc_r(7'h00, 5'd3, 5'd3, 3'd0, 5'd4), 1'b1, mk(32'hAA, 32'h55, 5'd4, 1, 0, 0, 1, 1), 1'b1);
    we = 1'b0;
    idle(2);
    wb(5'd4, 32'hAA);

    // SW x21,-4(x22) with x22=0x100
    wb(5'd22, 32'h100);
    send(enc_s(12'hFFC, 5'd21, 5'd22), 1'b1, mk(32'hFC, 32'h8000_0010, 5'd0, 0, 0, 1, 1, 0), 1'b1);
    idle(2);

    // unsupported opcode, then writes to x0 and reads of x0
    send(32'h0000_04B7, 1'b1, mk(32'd0, 32'd0, 5'd0, 0, 0, 0, 0, 0), 1'b0);
    chk("illegal_pulse", {31'd0, illegalD}, 32'd1);
    send(enc_i(12'd1, 5'd0, 3'd0, 5'd0, 7'd19), 1'b1, mk(32'd1, 32'd0, 5'd0, 0, 0, 0, 0, 1), 1'b1);
    chk("illegal_clear", {31'd0, illegalD}, 32'd0);
    send(enc_r(7'h00, 5'd0, 5'd0, 3'd0, 5'd26), 1'b1, mk(32'd0, 32'd0, 5'd26, 1, 0, 0, 1, 1), 1'b1);
    idle(2);
    wb(5'd26, 32'd0);

    // reset mid-stream drops in-flight work and clears scoreboard and registers
    send(enc_i(12'd1, 5'd0, 3'd0, 5'd28, 7'd19), 1'b1, mk(32'd1, 32'd0, 5'd28, 1, 0, 0, 0, 1), 1'b1);
    send(enc_i(12'd3, 5'd0, 3'd0, 5'd30, 7'd19), 1'b1, mk(32'd3, 32'd0, 5'd30, 1, 0, 0, 0, 1), 1'b1);
    instr_valid = 1'b0;
    #3;
    rst = 1'b1;
    sb_q.delete();
    #1;
    chk_zero("midrst");
    cycle();
    #2;
    rst = 1'b0;
    #1;
    chk("ready_after_midrst", {31'd0, instr_ready}, 32'd1);
    cycle();
    send(enc_r(7'h00, 5'd28, 5'd28, 3'd0, 5'd29), 1'b1, mk(32'd0, 32'd0, 5'd29, 1, 0, 0, 1, 1), 1'b1);
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
